// File: rtl/vx_cache_wb_sequencer.sv
// vx_cache_wb_sequencer: flush sequencer for a writeback cache bank.
// Walks every (line, way) entry, writes back valid dirty lines to memory
// with the dirty mask as byte enables, then clears the dirty bits.
// Optional feature macro: VX_CACHE_FLUSH_INVAL_EN (adds ds_inval so the
// bank is left empty after the flush).
module vx_cache_wb_sequencer #(
    parameter  int LINES     = 64,
    parameter  int NUM_WAYS  = 4,
    parameter  int LINE_SIZE = 16,
    parameter  int TAG_WIDTH = 20,
    localparam int LW        = $clog2(LINES),
    localparam int WW        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_valid,
    output logic                    flush_ready,
    output logic                    flush_done,
    input  logic                    core_idle,
    output logic                    ds_read,
    output logic                    ds_clear,
`ifdef VX_CACHE_FLUSH_INVAL_EN
    output logic                    ds_inval,
`endif
    output logic [LW-1:0]           ds_line_sel,
    output logic [NUM_WAYS-1:0]     ds_way_sel,
    input  logic                    ds_valid,
    input  logic [TAG_WIDTH-1:0]    ds_tag,
    input  logic [LINE_SIZE-1:0]    ds_dirty_byteen,
    input  logic [LINE_SIZE*8-1:0]  ds_line_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [TAG_WIDTH+LW-1:0] mem_req_addr,
    output logic [LINE_SIZE-1:0]    mem_req_byteen,
    output logic [LINE_SIZE*8-1:0]  mem_req_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_MEM_REQ,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [LW-1:0]            r_line;
    logic [WW-1:0]            r_way;
    logic                     r_flush_ready;
    logic                     r_flush_done;
    logic                     r_mem_req_valid;
    logic                     r_ds_clear;
    logic [TAG_WIDTH-1:0]     r_cap_tag;
    logic [LINE_SIZE-1:0]     r_cap_byteen;
    logic [LINE_SIZE*8-1:0]   r_cap_data;

    logic                     w_dirty_hit;
    logic                     w_advance;
    logic                     w_last_way;
    logic                     w_last_entry;
    logic [LW-1:0]            w_line_nxt;
    logic [WW-1:0]            w_way_nxt;

    // Entry classification and next (line, way) position for the walk
    always_comb begin
        w_dirty_hit  = ds_valid && (|ds_dirty_byteen);
        w_advance    = ((r_state == S_CHECK) && !w_dirty_hit) || (r_state == S_CLEAR);
        w_last_way   = (r_way == WW'(NUM_WAYS - 1));
        w_last_entry = w_last_way && (r_line == LW'(LINES - 1));
        w_way_nxt    = w_last_way ? '0 : r_way + WW'(1);
        w_line_nxt   = w_last_way ? r_line + LW'(1) : r_line;
    end

    // Walk FSM with its registered outputs and line capture registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_line          <= '0;
            r_way           <= '0;
            r_flush_ready   <= 1'b1;
            r_flush_done    <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_ds_clear      <= 1'b0;
            r_cap_tag       <= '0;
            r_cap_byteen    <= '0;
            r_cap_data      <= '0;
        end else begin
            r_flush_done <= 1'b0;
            r_ds_clear   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush_valid) begin
                        r_state       <= S_READ;
                        r_line        <= '0;
                        r_way         <= '0;
                        r_flush_ready <= 1'b0;
                    end
                end
                S_READ: begin
                    if (core_idle) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_cap_tag    <= ds_tag;
                    r_cap_byteen <= ds_dirty_byteen;
                    r_cap_data   <= ds_line_data;
                    if (w_dirty_hit) begin
                        r_state         <= S_MEM_REQ;
                        r_mem_req_valid <= 1'b1;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready) begin
                        r_state         <= S_CLEAR;
                        r_mem_req_valid <= 1'b0;
                        r_ds_clear      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                end
                S_DONE: begin
                    r_state       <= S_IDLE;
                    r_flush_ready <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_flush_ready <= 1'b1;
                end
            endcase
            // Advance is a same-cycle counter step shared by clean CHECK and CLEAR
            if (w_advance) begin
                if (w_last_entry) begin
                    r_state      <= S_DONE;
                    r_flush_done <= 1'b1;
                end else begin
                    r_state <= S_READ;
                    r_line  <= w_line_nxt;
                    r_way   <= w_way_nxt;
                end
            end
        end
    end

    // One-hot way select from the binary way counter
    always_comb begin
        ds_way_sel = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            ds_way_sel[i] = (r_way == WW'(i));
        end
    end

    // ds_read is gated by core_idle in the same cycle, so only the strobe is decoded live
    assign ds_read        = (r_state == S_READ) && core_idle;
    assign ds_clear       = r_ds_clear;
    assign ds_line_sel    = r_line;
    assign flush_ready    = r_flush_ready;
    assign flush_done     = r_flush_done;
    assign mem_req_valid  = r_mem_req_valid;
    assign mem_req_addr   = {r_cap_tag, r_line};
    assign mem_req_byteen = r_cap_byteen;
    assign mem_req_data   = r_cap_data;

`ifdef VX_CACHE_FLUSH_INVAL_EN
    // Invalidate clean valid entries on inspection, dirty ones after writeback
    assign ds_inval = (r_state == S_CLEAR) ||
                      ((r_state == S_CHECK) && ds_valid && !(|ds_dirty_byteen));
`endif

endmodule

// File: tb/tb_vx_cache_wb_sequencer.sv
// Directed testbench for vx_cache_wb_sequencer (LINES=4, NUM_WAYS=2).
// Includes a behavioural data/tag store with 1-cycle read latency.
module tb_vx_cache_wb_sequencer;

    localparam int LINES     = 4;
    localparam int NUM_WAYS  = 2;
    localparam int LINE_SIZE = 16;
    localparam int TAG_WIDTH = 20;
    localparam int LW        = 2;
    localparam int AW        = TAG_WIDTH + LW;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    flush_valid = 1'b0;
    logic                    flush_ready;
    logic                    flush_done;
    logic                    core_idle = 1'b1;
    logic                    ds_read;
    logic                    ds_clear;
`ifdef VX_CACHE_FLUSH_INVAL_EN
    logic                    ds_inval;
`endif
    logic [LW-1:0]           ds_line_sel;
    logic [NUM_WAYS-1:0]     ds_way_sel;
    logic                    ds_valid = 1'b0;
    logic [TAG_WIDTH-1:0]    ds_tag = '0;
    logic [LINE_SIZE-1:0]    ds_dirty_byteen = '0;
    logic [LINE_SIZE*8-1:0]  ds_line_data = '0;
    logic                    mem_req_valid;
    logic                    mem_req_ready = 1'b1;
    logic [AW-1:0]           mem_req_addr;
    logic [LINE_SIZE-1:0]    mem_req_byteen;
    logic [LINE_SIZE*8-1:0]  mem_req_data;

    vx_cache_wb_sequencer #(
        .LINES(LINES), .NUM_WAYS(NUM_WAYS), .LINE_SIZE(LINE_SIZE), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk), .reset(reset),
        .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_done(flush_done),
        .core_idle(core_idle), .ds_read(ds_read), .ds_clear(ds_clear),
`ifdef VX_CACHE_FLUSH_INVAL_EN
        .ds_inval(ds_inval),
`endif
        .ds_line_sel(ds_line_sel), .ds_way_sel(ds_way_sel),
        .ds_valid(ds_valid), .ds_tag(ds_tag), .ds_dirty_byteen(ds_dirty_byteen),
        .ds_line_data(ds_line_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen),
        .mem_req_data(mem_req_data)
    );

    always #5 clk = ~clk;

    // Store contents, loaded through a bench-side write port
    logic                   s_valid [LINES][NUM_WAYS];
    logic [TAG_WIDTH-1:0]   s_tag   [LINES][NUM_WAYS];
    logic [LINE_SIZE-1:0]   s_dirty [LINES][NUM_WAYS];
    logic [LINE_SIZE*8-1:0] s_data  [LINES][NUM_WAYS];

    logic                   ld_en = 1'b0;
    logic                   ld_wipe = 1'b0;
    logic [LW-1:0]          ld_line = '0;
    logic                   ld_way = 1'b0;
    logic                   ld_valid = 1'b0;
    logic [TAG_WIDTH-1:0]   ld_tag = '0;
    logic [LINE_SIZE-1:0]   ld_dirty = '0;
    logic [LINE_SIZE*8-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_wipe) begin
            for (int l = 0; l < LINES; l++)
                for (int w = 0; w < NUM_WAYS; w++) begin
                    s_valid[l][w] <= 1'b0;
                    s_dirty[l][w] <= '0;
                    s_tag[l][w]   <= '0;
                    s_data[l][w]  <= '0;
                end
        end else if (ld_en) begin
            s_valid[ld_line][ld_way] <= ld_valid;
            s_tag[ld_line][ld_way]   <= ld_tag;
            s_dirty[ld_line][ld_way] <= ld_dirty;
            s_data[ld_line][ld_way]  <= ld_data;
        end
        if (ds_read) begin
            ds_valid        <= s_valid[ds_line_sel][ds_way_sel[1]];
            ds_tag          <= s_tag[ds_line_sel][ds_way_sel[1]];
            ds_dirty_byteen <= s_dirty[ds_line_sel][ds_way_sel[1]];
            ds_line_data    <= s_data[ds_line_sel][ds_way_sel[1]];
        end
        if (ds_clear) s_dirty[ds_line_sel][ds_way_sel[1]] <= '0;
`ifdef VX_CACHE_FLUSH_INVAL_EN
        if (ds_inval) s_valid[ds_line_sel][ds_way_sel[1]] <= 1'b0;
`endif
    end

    // Event monitor, sampled mid-cycle
    int                     m_reads = 0, m_clears = 0, m_dones = 0, m_hs = 0, m_invals = 0;
    logic [LW-1:0]          m_clr_line = '0;
    logic [NUM_WAYS-1:0]    m_clr_way = '0;
    logic [AW-1:0]          m_addr = '0;
    logic [LINE_SIZE-1:0]   m_byteen = '0;
    logic [LINE_SIZE*8-1:0] m_data = '0;

    always @(negedge clk) begin
        if (ds_read) m_reads <= m_reads + 1;
        if (ds_clear) begin
            m_clears   <= m_clears + 1;
            m_clr_line <= ds_line_sel;
            m_clr_way  <= ds_way_sel;
        end
        if (flush_done) m_dones <= m_dones + 1;
        if (mem_req_valid && mem_req_ready) begin
            m_hs     <= m_hs + 1;
            m_addr   <= mem_req_addr;
            m_byteen <= mem_req_byteen;
            m_data   <= mem_req_data;
        end
`ifdef VX_CACHE_FLUSH_INVAL_EN
        if (ds_inval) m_invals <= m_invals + 1;
`endif
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int l, input int w, input logic v, input logic [TAG_WIDTH-1:0] t,
                        input logic [LINE_SIZE-1:0] d, input logic [LINE_SIZE*8-1:0] dat);
        ld_line = LW'(l); ld_way = w[0]; ld_valid = v; ld_tag = t; ld_dirty = d; ld_data = dat;
        ld_en = 1'b1;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wipe();
        ld_wipe = 1'b1;
        tick();
        ld_wipe = 1'b0;
    endtask

    task automatic start_flush();
        flush_valid = 1'b1;
        tick();
        flush_valid = 1'b0;
    endtask

    // Returns the cycle (counting the first cycle after accept as 1) in which flush_done is seen
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!flush_done && cyc < 500) begin
            tick();
            cyc++;
        end
        check("done_seen", flush_done, 1'b1);
        tick();
    endtask

    task automatic wait_req();
        int c = 0;
        while (!mem_req_valid && c < 200) begin
            tick();
            c++;
        end
        check("req_seen", mem_req_valid, 1'b1);
    endtask

    localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D3 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D4 = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
    localparam logic [127:0] D5 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    initial begin
        int cyc, r0, h0, d0, c0, i0;

        // Reset state
        tick(); tick();
        check("rst_flush_ready", flush_ready, 1'b1);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_way_sel", ds_way_sel, 2'b01);
        check("rst_line_sel", ds_line_sel, 2'd0);
        check("rst_ds_read", ds_read, 1'b0);
        check("rst_ds_clear", ds_clear, 1'b0);
        check("rst_mem_addr", mem_req_addr, '0);
        reset = 1'b1;
        tick();

        // 1: all clean; a request while busy is ignored
        wipe();
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < NUM_WAYS; w++)
                load(l, w, 1'b1, TAG_WIDTH'(l * 16 + w + 1), '0, D2);
        r0 = m_reads; h0 = m_hs; d0 = m_dones;
        start_flush();
        check("t1_ready_busy", flush_ready, 1'b0);
        tick(); tick(); tick();
        flush_valid = 1'b1;
        tick();
        flush_valid = 1'b0;
        wait_done(5, cyc);
        check("t1_cycles", cyc, 17);
        check("t1_reads", m_reads - r0, 8);
        check("t1_no_memreq", m_hs - h0, 0);
        check("t1_one_done", m_dones - d0, 1);
        check("t1_ready_idle", flush_ready, 1'b1);
        tick(); tick(); tick();
        check("t1_not_queued", m_reads - r0, 8);

        // 2: single dirty entry at line 2, way 1
        load(2, 1, 1'b1, 20'h5, 16'h000F, D2);
        h0 = m_hs; c0 = m_clears;
        start_flush();
        wait_done(1, cyc);
        check("t2_cycles", cyc, 19);
        check("t2_hs", m_hs - h0, 1);
        check("t2_addr", m_addr, 22'h16);
        check("t2_byteen", m_byteen, 16'h000F);
        check("t2_data", m_data, D2);
        check("t2_clears", m_clears - c0, 1);
        check("t2_clr_line", m_clr_line, 2'd2);
        check("t2_clr_way", m_clr_way, 2'b10);
        check("t2_dirty_zero", s_dirty[2][1], 16'h0);

        // 3: memory backpressure for 5 cycles
        load(1, 0, 1'b1, 20'hABCDE, 16'hF0F0, D3);
        h0 = m_hs;
        mem_req_ready = 1'b0;
        start_flush();
        wait_req();
        for (int i = 0; i < 5; i++) begin
            check("t3_valid_hold", mem_req_valid, 1'b1);
            check("t3_addr_hold", mem_req_addr, {20'hABCDE, 2'd1});
            check("t3_data_hold", mem_req_data, D3);
            check("t3_byteen_hold", mem_req_byteen, 16'hF0F0);
            tick();
        end
        check("t3_no_hs_yet", m_hs - h0, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        wait_done(1, cyc);
        check("t3_one_hs", m_hs - h0, 1);
        check("t3_hs_addr", m_addr, {20'hABCDE, 2'd1});
        mem_req_ready = 1'b1;

        // 4: core busy for 10 cycles at the start of the walk
        r0 = m_reads; h0 = m_hs;
        core_idle = 1'b0;
        start_flush();
        for (int i = 0; i < 10; i++) tick();
        check("t4_no_read", m_reads - r0, 0);
        check("t4_line_hold", ds_line_sel, 2'd0);
        core_idle = 1'b1;
        wait_done(11, cyc);
        check("t4_cycles", cyc, 27);
        check("t4_reads", m_reads - r0, 8);
        check("t4_no_memreq", m_hs - h0, 0);

        // 4b: core_idle toggling every cycle; CHECK is never cancelled
        load(3, 1, 1'b1, 20'h3C, 16'h8001, D4);
        r0 = m_reads; h0 = m_hs;
        start_flush();
        cyc = 1;
        while (!flush_done && cyc < 500) begin
            core_idle = ~core_idle;
            tick();
            cyc++;
        end
        check("t4b_done", flush_done, 1'b1);
        core_idle = 1'b1;
        tick();
        check("t4b_reads", m_reads - r0, 8);
        check("t4b_hs", m_hs - h0, 1);
        check("t4b_addr", m_addr, {20'h3C, 2'd3});
        check("t4b_data", m_data, D4);

        // 5: reset during MEM_REQ aborts the walk
        load(0, 1, 1'b1, 20'h77, 16'h0001, D5);
        h0 = m_hs; d0 = m_dones;
        mem_req_ready = 1'b0;
        start_flush();
        wait_req();
        reset = 1'b0;
        tick();
        check("t5_valid_drop", mem_req_valid, 1'b0);
        check("t5_ready", flush_ready, 1'b1);
        reset = 1'b1;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_hs", m_hs - h0, 0);
        check("t5_no_done", m_dones - d0, 0);
        check("t5_still_dirty", s_dirty[0][1], 16'h0001);

`ifdef VX_CACHE_FLUSH_INVAL_EN
        // 6: three valid lines, one dirty; bank empty afterwards
        wipe();
        load(0, 0, 1'b1, 20'h11, 16'h0000, D2);
        load(1, 1, 1'b1, 20'h22, 16'h00FF, D3);
        load(3, 0, 1'b1, 20'h33, 16'h0000, D4);
        h0 = m_hs; i0 = m_invals;
        start_flush();
        wait_done(1, cyc);
        check("t6_invals", m_invals - i0, 3);
        check("t6_hs", m_hs - h0, 1);
        check("t6_addr", m_addr, {20'h22, 2'd1});
        check("t6_v00", s_valid[0][0], 1'b0);
        check("t6_v11", s_valid[1][1], 1'b0);
        check("t6_v30", s_valid[3][0], 1'b0);
`else
        i0 = m_invals;
        check("no_inval_events", m_invals - i0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
